// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and counter-width helper for seq_mult_gen
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mult_abs.sv
// mult_abs: conditional two's-complement negate (x_i, neg_i -> y_o = neg_i ? -x_i : x_i)
module mult_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);
  always_comb y_o = neg_i ? -x_i : x_i;
endmodule

// File: rtl/seq_mult_gen.sv
// seq_mult_gen: shift-add multiplier; clk rst_n start signed_mode a b in, busy done res out
module seq_mult_gen
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SIGNED_EN  = 1,
  parameter int EARLY_TERM = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);
  localparam int CW = cnt_w(WIDTH);
  state_t             state_q, state_d;
  logic               neg_q, neg_d, busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, res_q, res_d, fix;
  logic [WIDTH-1:0]   mplier_q, mplier_d, abs_a, abs_b;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sm, last;
  assign sm = signed_mode & (SIGNED_EN != 0);
  mult_abs #(.W(WIDTH))   u_abs_a (.x_i(a), .neg_i(sm & a[WIDTH-1]), .y_o(abs_a));
  mult_abs #(.W(WIDTH))   u_abs_b (.x_i(b), .neg_i(sm & b[WIDTH-1]), .y_o(abs_b));
  mult_abs #(.W(2*WIDTH)) u_fix   (.x_i(acc_q), .neg_i(neg_q), .y_o(fix));
  assign last = (EARLY_TERM != 0) ? (mplier_q[WIDTH-1:1] == '0) : (cnt_q == CW'(WIDTH - 1));
  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    res_d    = res_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = CALC;
        neg_d    = sm & (a[WIDTH-1] ^ b[WIDTH-1]);
        mcand_d  = {{WIDTH{1'b0}}, abs_a};
        mplier_d = abs_b;
        acc_d    = '0;
        cnt_d    = '0;
        busy_d   = 1'b1;
        res_d    = '0;
      end
      CALC: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        state_d  = last ? FIX : CALC;
      end
      FIX: begin
        res_d   = fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
endmodule

// File: tb/tb_seq_mult_gen.sv
// tb_seq_mult_gen: directed table-driven check of seq_mult_gen in normal and early-termination builds
module tb_seq_mult_gen;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic        et;
    logic [31:0] r;
    int          lat;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sm = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  int          ncmp = 0, nerr = 0;
  vec_t        tv[10];
  always #5 clk = ~clk;
  seq_mult_gen #(.WIDTH(16), .SIGNED_EN(1), .EARLY_TERM(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .res(res0));
  seq_mult_gen #(.WIDTH(16), .SIGNED_EN(1), .EARLY_TERM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .res(res1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((busy0 || busy1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(busy0 | busy1), 32'd0);
  endtask
  task automatic pulse(input logic [15:0] xa, input logic [15:0] xb, input logic xs);
    a = xa; b = xb; sm = xs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input logic et, input string n, input int inj, output int e, output int bc);
    e = 0; bc = 0;
    while (!(et ? done1 : done0) && e < 60) begin
      if (et ? busy1 : busy0) bc++;
      if (inj != 0 && e == inj) begin
        a = 16'd1; b = 16'd1; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk({n, "_timeout"}, 32'(e < 60), 32'd1);
  endtask
  task automatic run(input vec_t v, input string n, input int inj);
    int e, bc;
    wait_idle();
    @(negedge clk);
    pulse(v.a, v.b, v.sm);
    chk({n, "_busy_rise"}, 32'(v.et ? busy1 : busy0), 32'd1);
    chk({n, "_res_clr"}, v.et ? res1 : res0, 32'd0);
    wait_done(v.et, n, inj, e, bc);
    chk({n, "_res"}, v.et ? res1 : res0, v.r);
    chk({n, "_lat"}, 32'(e), 32'(v.lat));
    chk({n, "_busycyc"}, 32'(bc), 32'(v.lat));
    chk({n, "_busy_fall"}, 32'(v.et ? busy1 : busy0), 32'd0);
    @(negedge clk);
    chk({n, "_done_pulse"}, 32'(v.et ? done1 : done0), 32'd0);
  endtask
  initial begin
    int e, bc, hit;
    tv[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 17};
    tv[1] = '{16'd11903, 16'd2753, 1'b0, 1'b0, 32'h01F403BF, 17};
    tv[2] = '{16'hFFFF, 16'h0002, 1'b1, 1'b0, 32'hFFFFFFFE, 17};
    tv[3] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 32'h40000000, 17};
    tv[4] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 32'hC0008000, 17};
    tv[5] = '{16'd127, 16'd255, 1'b0, 1'b1, 32'h00007E81, 9};
    tv[6] = '{16'd1234, 16'd0, 1'b0, 1'b1, 32'h00000000, 2};
    tv[7] = '{16'd3, 16'hFFFF, 1'b1, 1'b1, 32'hFFFFFFFD, 2};
    tv[8] = '{16'd2, 16'h8000, 1'b0, 1'b1, 32'h00010000, 17};
    tv[9] = '{16'd1, 16'h8000, 1'b1, 1'b1, 32'hFFFF8000, 17};
    #1;
    chk("rst_busy", 32'(busy0 | busy1), 32'd0);
    chk("rst_done", 32'(done0 | done1), 32'd0);
    chk("rst_res", res0 | res1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) run(tv[i], $sformatf("vec%0d", i), 0);
    run('{16'd10, 16'd20, 1'b0, 1'b0, 32'd200, 17}, "midstart", 3);
    wait_idle();
    @(negedge clk);
    pulse(16'd3, 16'd5, 1'b0);
    wait_done(1'b0, "b2b_a", 0, e, bc);
    chk("b2b_a_res", res0, 32'd15);
    chk("b2b_a_lat", 32'(e), 32'd17);
    pulse(16'd7, 16'd9, 1'b0);
    chk("b2b_accept_busy", 32'(busy0), 32'd1);
    chk("b2b_accept_res", res0, 32'd0);
    wait_done(1'b0, "b2b_b", 0, e, bc);
    chk("b2b_b_res", res0, 32'd63);
    chk("b2b_b_lat", 32'(e), 32'd17);
    wait_idle();
    @(negedge clk);
    pulse(16'd100, 16'd100, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy0 | busy1), 32'd0);
    chk("arst_done", 32'(done0 | done1), 32'd0);
    chk("arst_res", res0 | res1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    repeat (25) begin
      @(negedge clk);
      if (done0 || done1 || busy0 || busy1) hit++;
    end
    chk("arst_no_done", 32'(hit), 32'd0);
    run('{16'd100, 16'd100, 1'b0, 1'b0, 32'd10000, 17}, "post_rst", 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/seq_mult_gen.md
# seq_mult_gen

Parametrised sequential shift-add multiplier with a start/done handshake. It replaces the fixed 16x16 unsigned multiplier in the arithmetic datapath. Additions over the fixed version:
- operand width is a parameter;
- signed (two's-complement) or unsigned operation is selected per operation;
- an optional early-termination mode shortens latency for small multipliers;
- a `busy` status output is provided.

## Interface
Parameters:
- `WIDTH`, 16, operand width in bits (≥2); the product is 2·WIDTH bits.
- `SIGNED_EN`, 1, when 0 the `signed_mode` input is ignored and all operations are unsigned.
- `EARLY_TERM`, 0, when 1 the CALC state exits as soon as the remaining multiplier bits are all zero.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on a rising edge while `busy`=0.
- `signed_mode`  in  1  1 = two's-complement operands; sampled with `start`.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high from start acceptance until `done` is issued.
- `done`  out  1  one-cycle pulse; `res` is valid from this cycle.
- `res`  out  2·WIDTH  product; held until the next accepted `start`.

## Operation
- States:
  - IDLE → CALC on an accepted `start`.
  - CALC → FIX when the iteration count is reached.
  - FIX → IDLE unconditionally.
- Accept (edge E0): latch `neg = sm & (a[MSB]^b[MSB])`, where `sm = signed_mode & SIGNED_EN`. Latch `mcand = |a|` zero-extended to 2·WIDTH, `mplier = |b|` (WIDTH bits), `acc = 0`, `cnt = 0`, `busy ← 1`, `res ← 0`.
- Magnitude is taken only when `sm` = 1. The value −2^(WIDTH−1) maps to 2^(WIDTH−1), which fits in an unsigned WIDTH field.
- Each CALC edge:
  - if `mplier[0]` then `acc ← acc + mcand` (2·WIDTH-bit add, no overflow possible);
  - `mcand ← mcand << 1`, `mplier ← mplier >> 1`, `cnt ← cnt + 1`.
- CALC exit:
  - `EARLY_TERM`=0: after exactly WIDTH CALC edges.
  - `EARLY_TERM`=1: after the first CALC edge whose updated `mplier` is 0. There is always at least one CALC edge, including when b = 0.
- FIX edge: `res ← neg ? −acc : acc` (2·WIDTH two's complement), `done ← 1`, `busy ← 0`, state → IDLE.
- `done` is cleared on the following edge. The signed result of −2^(W−1)·−2^(W−1) = 2^(2W−2) is representable; no overflow flag exists.
- `start` while `busy`=1 is ignored: operands are not re-sampled and the run continues.
- `start` in the cycle `done`=1 is accepted, since `busy`=0. Back-to-back throughput is one result per (n+2) cycles.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `busy`=0, `done`=0, `res`=0, internal registers 0. A run in progress is abandoned and no `done` is produced.
- Latency with n CALC edges (n = WIDTH, or MSB index of |b| + 1 with a minimum of 1 when `EARLY_TERM`=1):
  - `busy` rises after E0;
  - `done` and the new `res` appear after edge E(n+1);
  - `busy` falls after the same edge.
- Default `WIDTH`=16, `EARLY_TERM`=0: `done` is 17 edges after the accepting edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mult_pkg`:
  - state enum {IDLE, CALC, FIX};
  - counter width function `$clog2(WIDTH+1)`.
- One natural sub-module, `mult_abs`: a combinational conditional two's-complement magnitude/negate unit, parameterised by width. It is instanced three times: |a|, |b| and the final negate.
- Everything else lives in `seq_mult_gen`.

## Test plan
- Unsigned, WIDTH=16: a=65535, b=65535 → `res`=0xFFFE0001; `done` 17 edges after accept; `busy` high 17 cycles.
- Unsigned: a=11903, b=2753 → 0x01F403BF. Then signed_mode=1, a=0xFFFF, b=0x0002 → 0xFFFFFFFE.
- Signed corner: a=b=0x8000, signed_mode=1 → 0x40000000. Then a=0x8000, b=0x7FFF → 0xC0008000.
- `EARLY_TERM`=1: a=127, b=255 → 0x00007E81 with `done` after 9 edges. b=0 → `res`=0 with `done` after 2 edges.
- Handshake:
  - pulse `start` with new operands mid-run → ignored, original product returned;
  - `start` coincident with `done` → second run accepted with no idle gap.
- Reset: assert `rst_n` low 5 cycles into a run → all outputs 0 immediately; no `done` after release; next run produces the correct result.
